// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of independent programmable clock dividers driven
// from the system clock.
//
// Each channel produces a 50 %-duty divided waveform (CLK_OUT) and a
// one-cycle TICK on the first high cycle of every output period. A ratio
// written through LOAD is held pending and only takes effect at a period
// boundary, or straight away while the channel is disabled. This keeps the
// waveform free of glitches. The outputs are clock enables for downstream
// logic and must not be used as clock pins.
//
// Ports:
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset (release synchronised upstream)
//   EN       per-channel run enable
//   DIV      packed ratio fields, channel i = DIV[i*WIDTH +: WIDTH]
//   LOAD     per-channel strobe capturing the DIV field as the pending ratio
//   CLK_OUT  divided waveform, registered (period 2*(ratio+1))
//   TICK     one-cycle pulse at the start of each period, registered
//   PENDING  a loaded ratio is waiting to be applied
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS-1:0]       EN,
  input  logic [CHANNELS*WIDTH-1:0] DIV,
  input  logic [CHANNELS-1:0]       LOAD,
  output logic [CHANNELS-1:0]       CLK_OUT,
  output logic [CHANNELS-1:0]       TICK,
  output logic [CHANNELS-1:0]       PENDING
);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] div_f;
    logic [WIDTH-1:0] act, act_n;
    logic [WIDTH-1:0] pnd, pnd_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic             pflag, pflag_n;
    logic             tick, tick_n;
    phase_t           ph, ph_n;

    assign div_f = DIV[g*WIDTH +: WIDTH];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        act   <= WIDTH'(DEFAULT_DIV);
        pnd   <= '0;
        pflag <= 1'b0;
        cnt   <= '0;
        ph    <= PH_LOW;
        tick  <= 1'b0;
      end else begin
        act   <= act_n;
        pnd   <= pnd_n;
        pflag <= pflag_n;
        cnt   <= cnt_n;
        ph    <= ph_n;
        tick  <= tick_n;
      end
    end

    always_comb begin
      act_n   = act;
      pnd_n   = pnd;
      pflag_n = pflag;
      cnt_n   = cnt;
      ph_n    = ph;
      tick_n  = 1'b0;

      if (!EN[g]) begin
        cnt_n = '0;
        ph_n  = PH_LOW;
        // An idle channel adopts its pending ratio at once, except when a
        // fresh LOAD arrives on the same edge: that value then stays pending.
        if (pflag && !LOAD[g]) begin
          act_n   = pnd;
          pflag_n = 1'b0;
        end
      end else if (cnt != '0) begin
        cnt_n = cnt - WIDTH'(1);
      end else if (ph == PH_HIGH) begin
        // Falling half-boundary: the ratio is never changed here.
        ph_n  = PH_LOW;
        cnt_n = act;
      end else begin
        ph_n   = PH_HIGH;
        tick_n = 1'b1;
        if (pflag) begin
          act_n   = pnd;
          cnt_n   = pnd;
          pflag_n = 1'b0;
        end else begin
          cnt_n = act;
        end
      end

      // The capture goes last so that a LOAD on a boundary edge re-arms the
      // pending flag after the boundary has consumed the older value.
      if (LOAD[g]) begin
        pnd_n   = div_f;
        pflag_n = 1'b1;
      end
    end

    assign CLK_OUT[g] = (ph == PH_HIGH);
    assign TICK[g]    = tick;
    assign PENDING[g] = pflag;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank (4 channels, 4-bit ratios, default ratio 0).
// When each stimulus is issued, the stimulus process queues the cycle
// numbers at which every channel must tick. A monitor checks TICK on each
// falling edge against those queues, and the stimulus process checks
// CLK_OUT/PENDING directly at hand-computed cycles.
module tb_clk_div_bank;

  localparam int CH = 4;
  localparam int W  = 4;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] en;
  logic [CH*W-1:0] div;
  logic [CH-1:0] load;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  int n_cmp;
  int n_bad;
  int cyc;
  int exp_q [CH][$];

  clk_div_bank #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .DEFAULT_DIV(0)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .EN     (en),
    .DIV    (div),
    .LOAD   (load),
    .CLK_OUT(clk_out),
    .TICK   (tick),
    .PENDING(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges so far; at a falling edge it names the
  // edge whose results are now visible.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_ch(input int ch, input int val);
    load[ch]      = 1'b1;
    div[ch*W +: W] = W'(val);
    step(1);
    load[ch] = 1'b0;
  endtask

  task automatic expect_tick(input int ch, input int at);
    exp_q[ch].push_back(at);
  endtask

  // Tick monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < CH; i++) begin
        if (tick[i]) begin
          n_cmp++;
          if (exp_q[i].size() == 0) begin
            n_bad++;
            $display("FAIL tick_unexpected ch%0d: tick at cycle %0d, required none", i, cyc);
          end else begin
            if (exp_q[i][0] != cyc) begin
              n_bad++;
              $display("FAIL tick_time ch%0d: tick at cycle %0d, required cycle %0d",
                       i, cyc, exp_q[i][0]);
            end
            void'(exp_q[i].pop_front());
          end
        end else if (exp_q[i].size() != 0 && exp_q[i][0] < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tick_missing ch%0d: no tick by cycle %0d, required at cycle %0d",
                   i, cyc, exp_q[i][0]);
          void'(exp_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en    = '0;
    div   = '0;
    load  = '0;

    // Reset state
    step(2);
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick",    int'(tick),    0);
    check("reset_pending", int'(pending), 0);
    rst_n = 1'b1;
    step(2);

    // Fixed ratio 3 on ch0: 4 high / 4 low, tick every 8 cycles
    load_ch(0, 3);
    check("a_pending_set", int'(pending[0]), 1);
    step(1);
    check("a_pending_applied_idle", int'(pending[0]), 0);
    c = cyc;
    en[0] = 1'b1;
    expect_tick(0, c + 1);
    expect_tick(0, c + 9);
    expect_tick(0, c + 17);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("a_clk_out", int'(clk_out[0]), ((k - 1) % 8) < 4 ? 1 : 0);
    end
    en[0] = 1'b0;
    step(2);

    // Live ratio change on ch1: 3 -> 1
    load_ch(1, 3);
    step(1);
    c = cyc;
    en[1] = 1'b1;
    expect_tick(1, c + 1);
    expect_tick(1, c + 9);
    expect_tick(1, c + 13);
    expect_tick(1, c + 17);
    expect_tick(1, c + 21);
    step(3);
    load_ch(1, 1);
    check("b_pending_rise", int'(pending[1]), 1);
    step(4);
    check("b_pending_held", int'(pending[1]), 1);
    step(1);
    check("b_pending_fall", int'(pending[1]), 0);
    check("b_clk_out_c9",   int'(clk_out[1]), 1);
    step(1);
    check("b_clk_out_c10",  int'(clk_out[1]), 1);
    step(1);
    check("b_clk_out_c11",  int'(clk_out[1]), 0);
    step(11);
    en[1] = 1'b0;
    step(2);

    // Simultaneous LOAD and boundary on ch2: 2 running, 5 pending, 0 loaded on the boundary
    load_ch(2, 2);
    step(1);
    c = cyc;
    en[2] = 1'b1;
    expect_tick(2, c + 1);
    expect_tick(2, c + 7);
    expect_tick(2, c + 19);
    expect_tick(2, c + 21);
    expect_tick(2, c + 23);
    step(3);
    load_ch(2, 5);
    step(1);
    check("c_pending_5", int'(pending[2]), 1);
    step(1);
    load_ch(2, 0);
    check("c_pending_0_after_boundary", int'(pending[2]), 1);
    check("c_clk_out_boundary",         int'(clk_out[2]), 1);
    step(11);
    check("c_pending_held", int'(pending[2]), 1);
    step(1);
    check("c_pending_fall", int'(pending[2]), 0);
    step(5);
    en[2] = 1'b0;
    step(2);

    // Enable toggling on ch3 (ratio 3)
    load_ch(3, 3);
    step(1);
    c = cyc;
    en[3] = 1'b1;
    expect_tick(3, c + 1);
    expect_tick(3, c + 6);
    expect_tick(3, c + 14);
    step(2);
    check("d_high_before_disable", int'(clk_out[3]), 1);
    en[3] = 1'b0;
    step(1);
    check("d_low_after_disable", int'(clk_out[3]), 0);
    step(2);
    en[3] = 1'b1;
    step(1);
    check("d_high_after_enable", int'(clk_out[3]), 1);
    step(3);
    check("d_high_end", int'(clk_out[3]), 1);
    step(1);
    check("d_low_start", int'(clk_out[3]), 0);
    step(5);
    en[3] = 1'b0;
    step(2);

    // Independence and maximum ratio: ratios 0, 1, 7, 15; LOAD 3 on ch2 mid-run
    load = '1;
    div  = {4'd15, 4'd7, 4'd1, 4'd0};
    step(1);
    load = '0;
    step(1);
    c = cyc;
    en = '1;
    for (int t = 1; t < 64; t += 2)  expect_tick(0, c + t);
    for (int t = 1; t < 64; t += 4)  expect_tick(1, c + t);
    expect_tick(2, c + 1);
    for (int t = 17; t < 64; t += 8) expect_tick(2, c + t);
    expect_tick(3, c + 1);
    expect_tick(3, c + 33);
    step(5);
    load_ch(2, 3);
    check("e_pending_only_ch2", int'(pending), 4);
    step(58);
    en = '0;
    step(2);

    // Reset mid-operation with CLK_OUT high and a ratio pending on ch1 (ratio 1)
    c = cyc;
    en[1] = 1'b1;
    expect_tick(1, c + 1);
    step(1);
    load_ch(1, 4);
    check("f_pre_clk_out", int'(clk_out[1]), 1);
    check("f_pre_pending", int'(pending[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("f_async_clk_out", int'(clk_out), 0);
    check("f_async_tick",    int'(tick),    0);
    check("f_async_pending", int'(pending), 0);
    en = '1;
    step(2);
    rst_n = 1'b1;
    c = cyc;
    for (int i = 0; i < CH; i++)
      for (int t = 1; t < 10; t += 2) expect_tick(i, c + t);
    step(1);
    check("f_release_clk_out", int'(clk_out), 15);
    check("f_release_pending", int'(pending), 0);
    step(9);
    en = '0;
    step(2);

    for (int i = 0; i < CH; i++) check("final_queue_empty", exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent programmable clock dividers driven from the single system clock `CLK`. Each channel produces a 50 %-duty divided clock-enable waveform and a one-cycle tick at the start of every output period. Divide ratios can be changed at run time without glitches: a new ratio takes effect only at a period boundary. The bank is the generalised successor to the fixed free-running clock source and feeds multi-rate timing to downstream counters and FSMs. All outputs are synchronous to `CLK`; they are not used as clock pins.

## Interface

Parameters:
- `CHANNELS`, 4: number of independent divider channels (≥1).
- `WIDTH`, 8: width of each divide field (≥1).
- `DEFAULT_DIV`, 0: active ratio loaded into every channel on reset (< 2^WIDTH).

Ports:
- `CLK`  in  1  system clock; all logic is rising-edge.
- `RST_N`  in  1  asynchronous, active-low reset; assertion is asynchronous and release is synchronous to `CLK` (synchronised upstream).
- `EN`  in  CHANNELS  per-channel run enable.
- `DIV`  in  CHANNELS*WIDTH  ratio fields; channel i uses `DIV[i*WIDTH +: WIDTH]`.
- `LOAD`  in  CHANNELS  per-channel strobe that captures the channel's `DIV` field into its pending register.
- `CLK_OUT`  out  CHANNELS  divided waveform, registered.
- `TICK`  out  CHANNELS  one-cycle pulse on the first high cycle of each `CLK_OUT` period, registered.
- `PENDING`  out  CHANNELS  high while a loaded ratio is waiting to be applied.

## Operation

Per-channel state:
- `act` (WIDTH): active ratio.
- `pnd` (WIDTH): pending ratio.
- `pflag`: pending flag.
- `cnt` (WIDTH): down-counter.
- `out`: drives `CLK_OUT`.
- `tick`: drives `TICK`.

Reset, while `RST_N` is low:
- `act = DEFAULT_DIV`, `pnd = 0`, `pflag = 0`, `cnt = 0`.
- `CLK_OUT = 0`, `TICK = 0`, `PENDING = 0`.

Each rising edge of `CLK`, for every channel independently:
- **LOAD capture:** if `LOAD[i]`, then `pnd <= DIV field` and `pflag <= 1`. This happens regardless of `EN`. A repeated `LOAD` overwrites `pnd`; only the last value is kept.
- **Disabled (`EN[i] = 0`):**
  - `cnt <= 0`, `out <= 0`, `tick <= 0`.
  - If `pflag` was set before this edge, then `act <= pnd` and `pflag <= 0`, unless `LOAD` is also asserted on this edge; in that case the new value stays pending.
- **Enabled, `cnt != 0`:** `cnt <= cnt - 1`, `tick <= 0`.
- **Enabled, `cnt == 0`, `out == 1` (falling half-boundary):**
  - `out <= 0`, `cnt <= act`, `tick <= 0`.
  - The ratio is never changed at this boundary.
- **Enabled, `cnt == 0`, `out == 0` (period boundary):**
  - `out <= 1`, `tick <= 1`.
  - If `pflag` was set before this edge, `act <= pnd`, `cnt <= pnd`, `pflag <= 0`; otherwise `cnt <= act`.
- **Simultaneous `LOAD` and boundary:** the boundary uses the value that was pending before the edge. The newly loaded value becomes pending and is applied at the next period boundary.
- `PENDING` is `pflag` directly.

Arithmetic:
- Half-period = `act + 1` cycles; full period = `2*(act+1)` cycles.
- The range runs from divide-by-2 (`act = 0`) to divide-by-2^(WIDTH+1).
- `cnt` never underflows, because the decrement occurs only when `cnt != 0`.

## Timing

- **Enable latency:** `EN` sampled high at edge k gives `CLK_OUT` = 1 and `TICK` = 1 in the cycle after edge k.
- **Disable latency:** `EN` sampled low at edge k gives `CLK_OUT` = 0 after edge k, truncating the current period. No tick is produced while disabled.
- **Tick:** `TICK` is high for exactly one cycle per period, coincident with the first high cycle of `CLK_OUT`.
- **Ratio change:** the current period always completes with the old ratio. The first period using the new ratio begins with the next tick.
- **Channel independence:** channels share no state and never interact.
- **Reset mid-operation:** all outputs go to reset values immediately, independent of `CLK`, and any pending ratio is discarded. After release, with `EN` high, the first tick arrives one cycle after the first sampled edge.

## Test plan

- **Reset values:** assert `RST_N = 0` mid-run with `CLK_OUT` high and `PENDING` = 1 → `CLK_OUT`, `TICK`, `PENDING` all 0 asynchronously, before the next `CLK` edge. After release with `EN = 1` and `DEFAULT_DIV = 0` → period 2, ticks every 2 cycles.
- **Fixed ratio:** ch0 loaded with `DIV = 3` while disabled, then enabled → `CLK_OUT` 4 cycles high / 4 low, `TICK` every 8 cycles, with the first tick 1 cycle after enable.
- **Live ratio change:** ch1 running at `DIV = 3`, `LOAD` with `DIV = 1` issued two cycles after a tick:
  - `PENDING` rises the next cycle.
  - The current 8-cycle period completes.
  - At the next tick, `PENDING` falls and the period becomes 4 (2 high / 2 low).
- **Simultaneous `LOAD` and boundary:** ch2 at `DIV = 2` with `DIV = 5` pending; issue `LOAD` with `DIV = 0` on the boundary edge:
  - Next period uses 5 (12 cycles).
  - `PENDING` stays 1 until the following tick, after which the period is 2.
- **Enable toggling:** deassert `EN[3]` during the high phase → `CLK_OUT` 0 on the next cycle, no tick. Reassert it → `CLK_OUT` = 1 and `TICK` = 1 one cycle later, then a full period follows.
- **Channel independence and maximum ratio:** `WIDTH = 4`, all channels running with ratios 0, 1, 7, 15 → periods 2, 4, 16, 32. Ticks align only on common multiples, and a `LOAD` on one channel does not disturb the others.
